regfile_write_queue: RTL
========================

Name: regfile_write_queue

Overview:
- Write-back buffer directly upstream of the register file; sole driver of its A3, WD3 and WE3 inputs.
- Accepts register writes from multi-cycle producers (ALU, multiplier, load unit) over a valid/ready handshake.
- Queues the writes in order and retires at most one per cycle into the register file.
- Reports pending-write hazards against the two register-file read addresses so decode can stall.

Parameters:
- ADDR_W, 5, register address width; matches A1/A2/A3.
- DATA_W, 32, register data width; matches WD3/RD1/RD2.
- DEPTH, 4, queue entries; power of two, minimum 2.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  asynchronous active-high reset.
- in_valid  input  1  producer offers a write.
- in_ready  output  1  queue can accept a write this cycle.
- in_addr  input  ADDR_W  destination register.
- in_data  input  DATA_W  write data.
- drain_en  input  1  retirement permitted this cycle; 0 = stall retirement.
- A3  output  ADDR_W  write address to register file.
- WD3  output  DATA_W  write data to register file.
- WE3  output  1  write enable to register file.
- A1  input  ADDR_W  read address 1 (shared with register file).
- A2  input  ADDR_W  read address 2 (shared with register file).
- pend1  output  1  a queued write targets A1.
- pend2  output  1  a queued write targets A2.
- fwd_hit1  output  1  forward data valid for A1 (FORWARD_EN only).
- fwd_data1  output  DATA_W  forwarded data for A1.
- fwd_hit2  output  1  forward data valid for A2.
- fwd_data2  output  DATA_W  forwarded data for A2.
- count  output  $clog2(DEPTH)+1  occupancy.

Behaviour:
- State: DEPTH-entry circular buffer of {addr, data}, head pointer, tail pointer, count. Pointers wrap modulo DEPTH.
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - count=0, pointers=0, storage cleared.
  - Outputs: WE3=0, A3=0, WD3=0, in_ready=1, pend*/fwd_hit*=0, fwd_data*=0.
- Push: occurs on a posedge when in_valid & in_ready. in_ready = (count != DEPTH). A full queue deasserts in_ready even if a pop happens in the same cycle (no combinational pop-to-ready path).
- Retire outputs are combinational from state:
  - WE3 = (count != 0) & drain_en.
  - A3 and WD3 show the head entry when count != 0, and are forced to 0 when empty.
- Pop: occurs on a posedge when WE3=1. The register file captures the write on that same edge.
- Latency: a write pushed into an empty queue appears on WE3 in the next cycle. There is no same-cycle bypass from input to WE3.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Ordering: strict FIFO. Duplicate addresses are allowed; the later write lands last.
- Hazard outputs:
  - pend1 = OR over valid entries of (addr == A1). pend2 likewise for A2.
  - The head entry being retired this cycle still counts as pending.
  - Purely combinational from state and A1/A2; in_* does not affect pend*.
- All address compares are full ADDR_W wide. Register 0 is not special.
- drain_en=0 holds the head entry indefinitely. The queue still fills and in_ready falls when count reaches DEPTH.

Optional Feature:
- Macro: REGFILE_WQ_FORWARD_EN.
- Defined:
  - fwd_hitN = pendN.
  - fwd_dataN = data of the youngest valid entry whose addr matches AN, or 0 on no match.
  - Decode may use the forwarded value instead of stalling.
- Undefined: fwd_hit1, fwd_hit2, fwd_data1 and fwd_data2 are tied to 0. The ports remain present.

Decomposition:
- Package regfile_pkg holds:
  - localparams REG_ADDR_W=5 and REG_DATA_W=32.
  - typedef wq_entry_t, a packed struct {addr, data}.
  - typedef wq_ptr_t.
- One sub-module, wq_match: takes the entry array, a valid mask, the head pointer and a lookup address; produces hit and youngest-match data.
  - Instantiated twice, once for A1 and once for A2.
  - Its data output is unused when REGFILE_WQ_FORWARD_EN is undefined.

Test Plan:
- Reset, then push {addr 3, 0xDEADBEEF} with drain_en=1 → next cycle WE3=1, A3=3, WD3=0xDEADBEEF; the following cycle WE3=0, count=0.
- drain_en=0, push addr 1,2,3,4 with data 0x11..0x44 → in_ready=0 after the 4th push, count=4; a 5th in_valid is ignored. Then set drain_en=1 → A3 sequence 1,2,3,4 on consecutive cycles; in_ready rises after the first pop.
- Queue holding addr 5 = 0xA then addr 5 = 0xB, A1=5, A2=6 → pend1=1, pend2=0. With forwarding: fwd_data1=0xB; after the first pop, still 0xB.
- Simultaneous push and pop at count=2 for 10 cycles, pointers wrapping → count stays 2; the WD3 sequence matches push order exactly.
- Assert RESET mid-drain with count=3 → WE3, A3, WD3 and count go to 0 immediately without waiting for CLK. After release, the first push reappears one cycle later.
- Empty queue with A1=0 → pend1=0 and WD3=0. Then push addr 0 = 0x7 → pend1=1 the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types for the register-file write-back queue.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int WQ_DEPTH   = 4;

    // One queued register write.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wq_entry_t;

    // Circular-buffer pointer; wraps naturally because WQ_DEPTH is a power of two.
    typedef logic [$clog2(WQ_DEPTH)-1:0] wq_ptr_t;

endpackage

// File: rtl/regfile_write_queue_if.sv
// Bundle of producer handshake, register-file write/read ports and hazard outputs.
// Latency: n/a (wiring only).
// Backpressure: in_ready from the queue; drain_en stalls retirement.
interface regfile_write_queue_if
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W,
    parameter int DEPTH  = WQ_DEPTH
);
    logic                       in_valid;
    logic                       in_ready;
    logic [ADDR_W-1:0]          in_addr;
    logic [DATA_W-1:0]          in_data;
    logic                       drain_en;
    logic [ADDR_W-1:0]          A3;
    logic [DATA_W-1:0]          WD3;
    logic                       WE3;
    logic [ADDR_W-1:0]          A1;
    logic [ADDR_W-1:0]          A2;
    logic                       pend1;
    logic                       pend2;
    logic                       fwd_hit1;
    logic [DATA_W-1:0]          fwd_data1;
    logic                       fwd_hit2;
    logic [DATA_W-1:0]          fwd_data2;
    logic [$clog2(DEPTH):0]     count;

    // Queue side.
    modport slave (
        input  in_valid, in_addr, in_data, drain_en, A1, A2,
        output in_ready, A3, WD3, WE3, pend1, pend2,
               fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count
    );

    // Producer / decode / register-file side.
    modport master (
        output in_valid, in_addr, in_data, drain_en, A1, A2,
        input  in_ready, A3, WD3, WE3, pend1, pend2,
               fwd_hit1, fwd_data1, fwd_hit2, fwd_data2, count
    );
endinterface

// File: rtl/wq_match.sv
// Looks up an address across valid queue entries: any-hit plus youngest matching data.
// Latency: combinational.
// Backpressure: none.
module wq_match
    import regfile_pkg::*;
#(
    parameter int DEPTH  = WQ_DEPTH,
    parameter bit FWD_EN = 1'b0
)
(
    input  wq_entry_t              entries [DEPTH],
    input  logic [DEPTH-1:0]       valid,
    input  wq_ptr_t                head,
    input  logic [REG_ADDR_W-1:0]  lookup,
    output logic                   hit,
    output logic [REG_DATA_W-1:0]  data
);

    logic [REG_DATA_W-1:0] youngest;
    wq_ptr_t               idx;

    // Walk oldest to youngest so the last match seen is the youngest write.
    always_comb begin
        hit      = 1'b0;
        youngest = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + wq_ptr_t'(i);
            if (valid[idx] && (entries[idx].addr == lookup)) begin
                hit      = 1'b1;
                youngest = entries[idx].data;
            end
        end
    end

    // Without forwarding the data path is dead; tie it off here so the top stays uniform.
    assign data = FWD_EN ? youngest : '0;

endmodule

// File: rtl/regfile_write_queue.sv
// In-order write-back queue feeding the register file (A3/WD3/WE3) with read-hazard flags; optional forwarding under REGFILE_WQ_FORWARD_EN.
// Latency: push to WE3 is one cycle minimum; retire, hazard and forward outputs are combinational from state.
// Backpressure: in_ready drops at DEPTH entries (no pop-to-ready bypass); drain_en=0 holds the head entry.
module regfile_write_queue
    import regfile_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W,
    parameter int DEPTH  = WQ_DEPTH
)
(
    input  logic                  CLK,
    input  logic                  RESET,
    regfile_write_queue_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

`ifdef REGFILE_WQ_FORWARD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    // Storage and pointers use the package types, so the geometry must agree with them.
    if (ADDR_W != REG_ADDR_W || DATA_W != REG_DATA_W || DEPTH != WQ_DEPTH) begin : g_bad_geometry
        $error("regfile_write_queue: parameters must match regfile_pkg");
    end

    wq_entry_t             mem_q [DEPTH];
    wq_ptr_t               head_q;
    wq_ptr_t               tail_q;
    logic [CNT_W-1:0]      count_q;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic [DEPTH-1:0]      valid_mask;
    logic [DATA_W-1:0]     match_data1;
    logic [DATA_W-1:0]     match_data2;
    wq_ptr_t               offset;

    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_W'(DEPTH));
    assign bus.in_ready = !full;
    assign push         = bus.in_valid && !full;
    assign pop          = !empty && bus.drain_en;

    assign bus.WE3   = pop;
    assign bus.A3    = empty ? '0 : mem_q[head_q].addr;
    assign bus.WD3   = empty ? '0 : mem_q[head_q].data;
    assign bus.count = count_q;

    // Slot j is live when its distance from head is below the occupancy.
    always_comb begin
        offset     = '0;
        valid_mask = '0;
        for (int j = 0; j < DEPTH; j++) begin
            offset        = wq_ptr_t'(j) - head_q;
            valid_mask[j] = ({1'b0, offset} < count_q);
        end
    end

    // Queue state: write at tail on push, advance head on retire, track occupancy.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[tail_q] <= '{addr: bus.in_addr, data: bus.in_data};
                tail_q        <= tail_q + 1'b1;
            end
            if (pop) begin
                head_q <= head_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    wq_match #(.DEPTH(DEPTH), .FWD_EN(FWD_EN)) u_match1 (
        .entries (mem_q),
        .valid   (valid_mask),
        .head    (head_q),
        .lookup  (bus.A1),
        .hit     (bus.pend1),
        .data    (match_data1)
    );

    wq_match #(.DEPTH(DEPTH), .FWD_EN(FWD_EN)) u_match2 (
        .entries (mem_q),
        .valid   (valid_mask),
        .head    (head_q),
        .lookup  (bus.A2),
        .hit     (bus.pend2),
        .data    (match_data2)
    );

    assign bus.fwd_hit1  = bus.pend1 & FWD_EN;
    assign bus.fwd_hit2  = bus.pend2 & FWD_EN;
    assign bus.fwd_data1 = match_data1;
    assign bus.fwd_data2 = match_data2;

endmodule
